// File: rtl/sdram_write_buffer_pkg.sv
// Shared constants for the SDRAM write-data buffer: default sizing, trigger FSM
// one-hot encodings and the state type.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional statistics outputs are enabled by defining SDRAM_WBUF_STATS_EN.
package sdram_write_buffer_pkg;

  localparam int WBUF_DATA_W    = 16;    // matches SDRAM dq width
  localparam int WBUF_DEPTH     = 1024;  // power of two, >= 2*burst
  localparam int WBUF_BURST_LEN = 512;   // words per SDRAM write burst
  localparam int WBUF_STAT_W    = 16;

  typedef logic [2:0] wbuf_state_t;

  // One-hot trigger FSM encodings (legacy-compatible constants).
  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_ARMED = 3'b010;
  localparam logic [2:0] ST_BURST = 3'b100;

endpackage

// File: rtl/sdram_write_buffer_if.sv
// Bundle of the buffer's user push side and write-engine pop side.
// Latency: n/a (wiring only). Backpressure: wr_full on the push side; the pop
// side is a bare strobe (write_data_vld) with no stall.
// Ports: wr_en/wr_data/wr_full/wr_level (user), write_trig/write_data_vld/w_dq
// (write engine), overflow/underflow (sticky status).
interface sdram_write_buffer_if
  import sdram_write_buffer_pkg::*;
#(
  parameter int DATA_W = WBUF_DATA_W,
  parameter int DEPTH  = WBUF_DEPTH
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic [LW-1:0]     wr_level;
  logic              write_trig;
  logic              write_data_vld;
  logic [DATA_W-1:0] w_dq;
  logic              overflow;
  logic              underflow;

  // Driver side: user data source plus write engine.
  modport master (
    output wr_en, wr_data, write_data_vld,
    input  wr_full, wr_level, write_trig, w_dq, overflow, underflow
  );

  // The buffer itself.
  modport slave (
    input  wr_en, wr_data, write_data_vld,
    output wr_full, wr_level, write_trig, w_dq, overflow, underflow
  );

endinterface

// File: rtl/sdram_wbuf_ram.sv
// Simple dual-port storage for the write buffer, one write and one read port.
// Latency: read data registered, 1 cycle after rd_addr. Backpressure: none.
// Ports: sysclk_100M, wr_en/wr_addr/wr_data (write), rd_addr/rd_data (read).
module sdram_wbuf_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                     sysclk_100M,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or the read register so this maps onto block RAM.
  always_ff @(posedge sysclk_100M) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sdram_write_buffer.sv
// Show-ahead write-data FIFO feeding the SDRAM write engine; raises write_trig once a burst is stored.
// Latency: push -> w_dq 1 cycle; push reaching BURST_LEN words -> write_trig 1 cycle.
// Backpressure: pushes dropped while wr_full (sticky overflow); pops while empty ignored (sticky underflow).
// Ports: sysclk_100M, rst_n (async active-low), bus (sdram_write_buffer_if.slave).
// Build option SDRAM_WBUF_STATS_EN adds drop_cnt (saturating) and burst_cnt (wrapping).
module sdram_write_buffer
  import sdram_write_buffer_pkg::*;
#(
  parameter int DATA_W    = WBUF_DATA_W,
  parameter int DEPTH     = WBUF_DEPTH,
  parameter int BURST_LEN = WBUF_BURST_LEN
) (
  input  logic                   sysclk_100M,
  input  logic                   rst_n,
  sdram_write_buffer_if.slave    bus
`ifdef SDRAM_WBUF_STATS_EN
  ,
  output logic [WBUF_STAT_W-1:0] drop_cnt,
  output logic [WBUF_STAT_W-1:0] burst_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BURST_LEN) + 1;

  logic [LW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LW-1:0]     level, level_nxt;
  logic              full, empty;
  logic              push_ok, pop_ok, drop;
  logic              head_from_push;
  logic              use_byp;
  logic [DATA_W-1:0] byp_dat;
  logic [DATA_W-1:0] ram_q;
  logic              overflow_q, underflow_q;
  wbuf_state_t       state;
  logic [CW-1:0]     burst_pops;
  logic              burst_last;

  // Pointers carry a wrap bit: equal addresses with differing MSBs means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign pop_ok  = bus.write_data_vld && !empty;
  // At full a simultaneous pop frees the slot the push lands in.
  assign push_ok = bus.wr_en && (!full || pop_ok);
  assign drop    = bus.wr_en && full && !pop_ok;

  assign wr_ptr_nxt = wr_ptr + LW'(push_ok);
  assign rd_ptr_nxt = rd_ptr + LW'(pop_ok);
  assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  // The pushed word becomes the head when nothing older survives this cycle;
  // RAM cannot return a word written on the same edge, so it is captured directly.
  assign head_from_push = push_ok && (level_nxt == LW'(1));

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (bus.write_data_vld && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // The RAM is always addressed with the next read pointer, so its registered
  // output is already the head word in the cycle after a pop.
  sdram_wbuf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .sysclk_100M (sysclk_100M),
    .wr_en       (push_ok),
    .wr_addr     (wr_ptr[AW-1:0]),
    .wr_data     (bus.wr_data),
    .rd_addr     (rd_ptr_nxt[AW-1:0]),
    .rd_data     (ram_q)
  );

  // Head source select: bypass register after a push into an (effectively)
  // empty FIFO, RAM output after a pop; held otherwise. Reset selects the
  // zeroed bypass register so w_dq starts at 0.
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      use_byp <= 1'b1;
      byp_dat <= '0;
    end else if (head_from_push) begin
      use_byp <= 1'b1;
      byp_dat <= bus.wr_data;
    end else if (pop_ok) begin
      use_byp <= 1'b0;
    end
  end

  assign burst_last = (state == ST_BURST) && pop_ok && (burst_pops == CW'(BURST_LEN - 1));

  // Trigger FSM. IDLE looks at the post-update level so the trigger follows
  // the completing push by one cycle. The pop counter only advances on
  // accepted pops, so gaps in write_data_vld simply stall it.
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      burst_pops <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (level_nxt >= LW'(BURST_LEN)) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (pop_ok) begin
            state      <= ST_BURST;
            burst_pops <= CW'(1);
          end
        end
        ST_BURST: begin
          if (burst_last) begin
            state      <= ST_IDLE;
            burst_pops <= '0;
          end else if (pop_ok) begin
            burst_pops <= burst_pops + CW'(1);
          end
        end
        default: begin
          state      <= ST_IDLE;
          burst_pops <= '0;
        end
      endcase
    end
  end

`ifdef SDRAM_WBUF_STATS_EN
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      if (drop && (drop_cnt != {WBUF_STAT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + WBUF_STAT_W'(1);
      end
      if (burst_last) begin
        burst_cnt <= burst_cnt + WBUF_STAT_W'(1);
      end
    end
  end
`endif

  assign bus.wr_full    = full;
  assign bus.wr_level   = level;
  assign bus.write_trig = (state == ST_ARMED);
  assign bus.w_dq       = use_byp ? byp_dat : ram_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

endmodule
